// File: rtl/state_dump_pkg.sv
// Shared types and constants for the save-state snapshot path.
package state_dump_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HEADER,
      S_STREAM,
      S_CHECKSUM,
      S_DONE
   } dump_state_t;

   localparam logic [7:0] DUMP_HEADER    = 8'h5A;
   localparam logic [8:0] DUMP_LAST_ADDR = 9'h11B;
   localparam int         DUMP_FRAME_LEN = 286;

endpackage

// File: rtl/state_dumper_if.sv
// Byte stream from the state dumper to the MCU-side transport.
interface state_dumper_if;
   import state_dump_pkg::*;

   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;

   modport master (output out_data, output out_valid, output out_last, input out_ready);
   modport slave  (input out_data, input out_valid, input out_last, output out_ready);

endinterface

// File: rtl/stream_skid2.sv
// Two-entry valid/ready buffer; credit reports free entries so a producer
// with read latency can throttle issue without an in_ready round trip.
module stream_skid2 #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [1:0]        credit
);

   logic [DATA_W-1:0] head_q;
   logic [DATA_W-1:0] tail_q;
   logic [1:0]        count_q;
   logic              push;
   logic              pop;

   assign push      = in_valid && (count_q != 2'd2);
   assign pop       = out_valid && out_ready;
   assign out_valid = (count_q != 2'd0);
   assign out_data  = out_valid ? head_q : '0;
   assign credit    = 2'd2 - count_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= 2'd0;
      end else if (flush) begin
         count_q <= 2'd0;
      end else begin
         count_q <= count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   // Head always holds the oldest byte so it stays stable until popped.
   always_ff @(posedge clk) begin
      if (pop) begin
         if (count_q == 2'd2) begin
            head_q <= tail_q;
         end else if (push) begin
            head_q <= in_data;
         end
      end else if (push) begin
         if (count_q == 2'd0) begin
            head_q <= in_data;
         end else begin
            tail_q <= in_data;
         end
      end
   end

endmodule

// File: rtl/state_dumper.sv
// Walks the recorder readout port and frames it as header, data bytes and
// an XOR checksum on a valid/ready byte stream.
module state_dumper
   import state_dump_pkg::*;
#(
   parameter logic [7:0] HEADER    = DUMP_HEADER,
   parameter logic [8:0] LAST_ADDR = DUMP_LAST_ADDR
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           start,
   input  logic           abort,
   output logic           busy,
   output logic           done,
   output logic [8:0]     read_addr,
   input  logic [7:0]     read_data,
   state_dumper_if.master dump
);

   dump_state_t state_q;
   logic [8:0]  iss_cnt_q;
   logic        iss_done_q;
   logic        rd_vld_p1;
   logic [8:0]  acc_cnt_q;
   logic [7:0]  csum_q;

   logic [7:0]  buf_data;
   logic        buf_valid;
   logic        buf_ready;
   logic [1:0]  credit;
   logic        flush;
   logic        fetching;
   logic        start_ok;
   logic        pop;
   logic        hs_out;
   logic        issue;

   assign read_addr = iss_cnt_q;
   assign fetching  = (state_q == S_HEADER) || (state_q == S_STREAM);
   assign start_ok  = (state_q == S_IDLE) && start && !abort;
   assign flush     = abort && (state_q != S_IDLE);
   assign buf_ready = (state_q == S_STREAM) && dump.out_ready;
   assign pop       = buf_valid && buf_ready;
   assign hs_out    = dump.out_valid && dump.out_ready;

   // read_addr rests at 0 in IDLE, so the start cycle itself issues address 0.
   // Afterwards a read may issue only if the byte still in flight plus this
   // one fit in the space left after this cycle's pop.
   assign issue = start_ok ||
                  (fetching && !abort && !iss_done_q &&
                   ({2'b00, rd_vld_p1} < ({1'b0, credit} + {2'b00, pop})));

   stream_skid2 #(
      .DATA_W (8)
   ) u_skid (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .in_data   (read_data),
      .in_valid  (rd_vld_p1),
      .out_data  (buf_data),
      .out_valid (buf_valid),
      .out_ready (buf_ready),
      .credit    (credit)
   );

   always_comb begin
      dump.out_valid = 1'b0;
      dump.out_data  = 8'h00;
      dump.out_last  = 1'b0;
      case (state_q)
         S_HEADER: begin
            dump.out_valid = 1'b1;
            dump.out_data  = HEADER;
         end
         S_STREAM: begin
            dump.out_valid = buf_valid;
            dump.out_data  = buf_data;
         end
         S_CHECKSUM: begin
            dump.out_valid = 1'b1;
            dump.out_data  = csum_q;
            dump.out_last  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         iss_cnt_q  <= 9'd0;
         iss_done_q <= 1'b0;
         rd_vld_p1  <= 1'b0;
         acc_cnt_q  <= 9'd0;
         csum_q     <= 8'h00;
      end else begin
         done      <= 1'b0;
         rd_vld_p1 <= issue;
         if (issue) begin
            iss_done_q <= (iss_cnt_q == LAST_ADDR);
            if (iss_cnt_q != LAST_ADDR) begin
               iss_cnt_q <= iss_cnt_q + 9'd1;
            end
         end
         if (pop) begin
            csum_q <= csum_q ^ buf_data;
         end

         if (flush) begin
            state_q    <= S_IDLE;
            busy       <= 1'b0;
            iss_cnt_q  <= 9'd0;
            iss_done_q <= 1'b0;
            rd_vld_p1  <= 1'b0;
            acc_cnt_q  <= 9'd0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start_ok) begin
                     state_q   <= S_HEADER;
                     busy      <= 1'b1;
                     acc_cnt_q <= 9'd0;
                     csum_q    <= 8'h00;
                  end
               end
               S_HEADER: begin
                  if (hs_out) begin
                     state_q <= S_STREAM;
                  end
               end
               S_STREAM: begin
                  if (pop) begin
                     if (acc_cnt_q == LAST_ADDR) begin
                        state_q <= S_CHECKSUM;
                     end else begin
                        acc_cnt_q <= acc_cnt_q + 9'd1;
                     end
                  end
               end
               S_CHECKSUM: begin
                  if (hs_out) begin
                     state_q <= S_DONE;
                     done    <= 1'b1;
                  end
               end
               S_DONE: begin
                  state_q    <= S_IDLE;
                  busy       <= 1'b0;
                  iss_cnt_q  <= 9'd0;
                  iss_done_q <= 1'b0;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_state_dumper.sv
// Directed bench for state_dumper with a byte scoreboard on the output stream.
module tb_state_dumper;
   import state_dump_pkg::*;

   typedef struct {
      logic [7:0] data;
      logic       last;
      int         cyc;
      int         idx;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start;
   logic       abort;
   logic       busy;
   logic       done;
   logic [8:0] read_addr;
   logic [7:0] read_data;
   logic [7:0] mem [0:511];

   state_dumper_if dump();

   state_dumper dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .abort     (abort),
      .busy      (busy),
      .done      (done),
      .read_addr (read_addr),
      .read_data (read_data),
      .dump      (dump)
   );

   always #5 clk = ~clk;

   // Recorder readout register: one cycle of latency.
   always @(posedge clk) read_data <= mem[read_addr];

   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         checks = 0;
   int         failures = 0;
   exp_t       exp_q[$];
   int         t0 = 0;
   int         last_idx = -1;
   int         frame_hs = 0;
   int         done_cnt = 0;
   logic       pend = 1'b0;
   logic [7:0] pend_data = 8'h00;
   logic       prev_abort = 1'b0;
   logic [7:0] csum_ref;

   function automatic logic [7:0] pat(input int a);
      logic [8:0] aa;
      aa = a[8:0];
      return aa[7:0] ^ {7'b0, aa[8]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input bit timed);
      exp_t e;
      e.data = DUMP_HEADER; e.last = 1'b0; e.idx = 0; e.cyc = timed ? 1 : -1;
      exp_q.push_back(e);
      for (int n = 0; n <= int'(DUMP_LAST_ADDR); n++) begin
         e.data = pat(n); e.last = 1'b0; e.idx = n + 1; e.cyc = timed ? n + 2 : -1;
         exp_q.push_back(e);
      end
      e.data = csum_ref; e.last = 1'b1; e.idx = DUMP_FRAME_LEN - 1;
      e.cyc = timed ? DUMP_FRAME_LEN : -1;
      exp_q.push_back(e);
      last_idx = -1;
      frame_hs = 0;
      t0 = cyc;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic timed_tail(input string tag);
      int d0;
      d0 = done_cnt;
      chk({tag, "_busy_c1"}, busy, 1'b1);
      chk({tag, "_hdr_valid_c1"}, dump.out_valid, 1'b1);
      chk({tag, "_hdr_data_c1"}, dump.out_data, DUMP_HEADER);
      while (cyc - t0 < DUMP_FRAME_LEN + 1) step();
      chk({tag, "_done_c287"}, done, 1'b1);
      chk({tag, "_busy_c287"}, busy, 1'b1);
      step();
      chk({tag, "_done_c288"}, done, 1'b0);
      chk({tag, "_busy_c288"}, busy, 1'b0);
      chk({tag, "_sb_drained"}, exp_q.size(), 0);
      chk({tag, "_frame_len"}, frame_hs, DUMP_FRAME_LEN);
      chk({tag, "_done_pulses"}, done_cnt, d0 + 1);
   endtask

   task automatic wait_end(input string tag, input int budget, input bit rnd);
      int n;
      n = 0;
      while ((busy || exp_q.size() != 0) && n < budget) begin
         if (rnd) dump.out_ready = ($urandom_range(0, 99) < 40);
         step();
         n++;
      end
      dump.out_ready = 1'b1;
      chk({tag, "_end_in_budget"}, n < budget, 1'b1);
   endtask

   task automatic wait_idx(input string tag, input int idx, input int budget);
      int n;
      n = 0;
      while (last_idx != idx && n < budget) begin
         step();
         n++;
      end
      chk({tag, "_reach_idx"}, last_idx, idx);
   endtask

   // Output monitor: scoreboard pops, hold-stability and done counting.
   always @(negedge clk) begin
      exp_t e;
      if (!reset_n) begin
         pend = 1'b0;
      end else begin
         if (pend && !prev_abort) begin
            chk("hold_valid", dump.out_valid, 1'b1);
            chk("hold_data", dump.out_data, pend_data);
         end
         if (done) done_cnt++;
         if (dump.out_valid && dump.out_ready) begin
            chk("sb_nonempty", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("sb_data", dump.out_data, e.data);
               chk("sb_last", dump.out_last, e.last);
               if (e.cyc >= 0) chk("sb_cycle", cyc - t0, e.cyc);
               last_idx = e.idx;
               frame_hs++;
            end
         end
         pend       = dump.out_valid && !dump.out_ready;
         pend_data  = dump.out_data;
         prev_abort = abort;
      end
   end

   initial begin
      int         d0;
      logic [8:0] ra;

      for (int i = 0; i < 512; i++) mem[i] = pat(i);
      csum_ref = 8'h00;
      for (int i = 0; i <= int'(DUMP_LAST_ADDR); i++) csum_ref = csum_ref ^ pat(i);

      reset_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      dump.out_ready = 1'b0;
      #2;
      chk("rst_read_addr", read_addr, 9'd0);
      chk("rst_out_data", dump.out_data, 8'h00);
      chk("rst_out_valid", dump.out_valid, 1'b0);
      chk("rst_out_last", dump.out_last, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      step();

      // Full frame with the consumer always ready, cycle-exact.
      dump.out_ready = 1'b1;
      start_frame(1'b1);
      timed_tail("t1");

      // Random backpressure: same byte sequence, held while stalled.
      d0 = done_cnt;
      start_frame(1'b0);
      wait_end("t2", 4000, 1'b1);
      chk("t2_frame_len", frame_hs, DUMP_FRAME_LEN);
      chk("t2_done_pulses", done_cnt, d0 + 1);

      // Long stall right after data[10].
      dump.out_ready = 1'b1;
      start_frame(1'b0);
      wait_idx("t3", 11, 100);
      dump.out_ready = 1'b0;
      repeat (3) step();
      ra = read_addr;
      chk("t3_addr_bound", ra <= 9'd13, 1'b1);
      chk("t3_stall_valid", dump.out_valid, 1'b1);
      chk("t3_stall_head", dump.out_data, pat(11));
      repeat (47) step();
      chk("t3_addr_frozen", read_addr, ra);
      chk("t3_stall_head_late", dump.out_data, pat(11));
      dump.out_ready = 1'b1;
      wait_end("t3", 1000, 1'b0);

      // Abort while data[100] is presented, then a clean frame.
      start_frame(1'b0);
      wait_idx("t4", 100, 400);
      dump.out_ready = 1'b0;
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("t4_valid_after_abort", dump.out_valid, 1'b0);
      chk("t4_busy_after_abort", busy, 1'b0);
      d0 = done_cnt;
      repeat (5) step();
      chk("t4_no_done", done_cnt, d0);
      chk("t4_idle_busy", busy, 1'b0);
      exp_q.delete();
      dump.out_ready = 1'b1;
      start_frame(1'b1);
      timed_tail("t4");

      // Second start while busy is ignored.
      d0 = done_cnt;
      start_frame(1'b0);
      wait_idx("t5", 5, 100);
      start = 1'b1;
      step();
      start = 1'b0;
      wait_end("t5", 1000, 1'b0);
      chk("t5_frame_len", frame_hs, DUMP_FRAME_LEN);
      chk("t5_done_pulses", done_cnt, d0 + 1);
      repeat (5) step();
      chk("t5_stays_idle", busy, 1'b0);
      chk("t5_no_extra_valid", dump.out_valid, 1'b0);

      // Asynchronous reset mid-stream.
      start_frame(1'b0);
      wait_idx("t6", 50, 200);
      #2 reset_n = 1'b0;
      #1;
      chk("t6_rst_read_addr", read_addr, 9'd0);
      chk("t6_rst_out_data", dump.out_data, 8'h00);
      chk("t6_rst_out_valid", dump.out_valid, 1'b0);
      chk("t6_rst_out_last", dump.out_last, 1'b0);
      chk("t6_rst_busy", busy, 1'b0);
      chk("t6_rst_done", done, 1'b0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      step();
      start_frame(1'b1);
      timed_tail("t6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/state_dumper.md
# state_dumper

Downstream consumer of the sniffed-state recorder's readout port. On a start request it walks recorder addresses 0x000–0x11B (OAM, APU, PPU shadow), frames them as a byte stream (header, 284 data bytes, XOR checksum) and hands them to the MCU-side transport over a valid/ready interface. It provides the save-state snapshot path.

## Interface
- `HEADER`, default 8'h5A: first byte of every frame.
- `LAST_ADDR`, default 9'h11B: final recorder address read; frame carries LAST_ADDR+1 data bytes.
- `clk`  in  1: single clock; the same clock that drives the recorder readout register.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle request; honoured only in IDLE.
- `abort`  in  1: cancels the frame in progress; wins over `start`.
- `busy`  out  1: high from the cycle after an accepted start until the return to IDLE.
- `done`  out  1: one-cycle pulse after the checksum handshake.
- `read_addr`  out  9: recorder readout address.
- `read_data`  in  8: recorder byte for the `read_addr` of the previous cycle (1-cycle latency).
- `out_data`  out  8: stream byte.
- `out_valid`  out  1: `out_data` is valid.
- `out_ready`  in  1: consumer accepts; a transfer occurs when `out_valid && out_ready`.
- `out_last`  out  1: high with the checksum byte only.

## Operation
- FSM states: IDLE, HEADER, STREAM, CHECKSUM, DONE.
- IDLE → HEADER on `start`. Clear the checksum accumulator, clear the issue counter and the accept counter.
- HEADER: present `HEADER` byte. Prefetch of address 0 begins in the same cycle. On handshake → STREAM.
- STREAM:
  - The issue counter drives `read_addr` and advances while a 2-entry buffer has a free credit. Credit = entries held + reads in flight ≤ 2.
  - Each `read_data` is pushed into the buffer one cycle after issue.
  - The buffer head drives `out_data`.
  - Every accepted byte is XORed into the checksum.
  - Leave for CHECKSUM when byte LAST_ADDR is accepted.
- The issue counter stops at LAST_ADDR. It never wraps or reads past the end.
- CHECKSUM: present the accumulator with `out_last`=1. On handshake → DONE.
- DONE: assert `done` for one cycle → IDLE.
- Stream rule: once `out_valid` rises, `out_data` and `out_valid` stay stable until the handshake. `abort` is the only exception.
- `abort` in any non-IDLE state:
  - → IDLE next cycle.
  - Buffer is flushed and `out_valid` drops.
  - No checksum byte and no `done`.
- `start` while `busy` is ignored.
- Snapshot is not atomic: recorder writes landing during the walk are read as-is. The caller pauses the recorder if coherency matters.

## Timing
- Reset values: `read_addr`=0, `out_data`=0, `out_valid`=0, `out_last`=0, `busy`=0, `done`=0; FSM=IDLE; checksum=0.
- `start` at cycle 0 produces `busy`=1 and the header valid at cycle 1.
- With `out_ready` held high:
  - data[n] is transferred at cycle 2+n.
  - The checksum is transferred at cycle 286 (default LAST_ADDR).
  - `done` pulses at cycle 287.
  - `busy` falls at cycle 288.
- Sustained throughput is 1 byte/cycle. Backpressure of any length loses and duplicates no byte.
- `out_ready` deasserting mid-stream stalls issue within 2 reads. Buffered bytes are preserved.
- Reset assertion at any point returns all outputs to reset values immediately (asynchronous).

## Structure
- Package `state_dump_pkg` holds:
  - the FSM state enum `dump_state_t`;
  - `DUMP_HEADER` = 8'h5A;
  - `DUMP_LAST_ADDR` = 9'h11B;
  - `DUMP_FRAME_LEN` = 286 (header + 284 data + checksum).
- Sub-module `stream_skid2`: 2-entry valid/ready buffer with a credit output. It is reused by other MCU-side streams.
- Top level holds the FSM, the issue and accept counters, and the checksum accumulator.

## Test plan
- Preload recorder with byte = addr[7:0] ^ addr[8], `out_ready`=1, pulse `start` → 286 bytes: 8'h5A, then the pattern, then its XOR with `out_last`; `done` at cycle 287.
- Random `out_ready` (≈40% duty) → identical byte sequence to the above; no gaps in ordering; `out_data` stable while valid and not ready.
- `out_ready`=0 for 50 cycles after data[10] → `read_addr` stops advancing by data[12]; resuming yields data[11] next.
- `abort` at data[100] → `out_valid`=0 next cycle, `busy`=0, no `done`; a new `start` then produces a full, correct frame.
- `start` pulsed again at data[5] → ignored; frame length is still 286.
- `reset_n` low mid-STREAM → all outputs 0 asynchronously; after release, `start` gives a clean frame.
